// File: rtl/uart_axi_buffer_if.sv
// rtl/uart_axi_buffer_if.sv - AXI4-Lite bus bundle between the core's UART window and the buffer
//
// Purpose: groups the five AXI4-Lite channels so the buffer and its master
// connect through one port.
// Signals:
//   AR: araddr, arvalid, arready    R: rdata, rresp, rvalid, rready
//   AW: awaddr, awvalid, awready    W: wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready
// Modports: master drives addresses/data/ready-for-response, slave the rest.

interface uart_axi_buffer_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/uart_axi_buffer.sv
// rtl/uart_axi_buffer.sv - AXI4-Lite slave buffering UART bytes in RX and TX FIFOs
//
// Purpose: the core reads RX bytes at 0x0, writes TX bytes at 0x4 and reads
// status {rx_overrun, tx_full, rx_nonempty} at 0x8. A read of an empty RX FIFO
// or a write to a full TX FIFO is held without a response until it can
// complete, so the core never has to poll.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   s_axi            AXI4-Lite slave (uart_axi_buffer_if.slave)
//   rx_data/rx_valid byte strobe from the UART receiver
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter

module uart_axi_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_axi_buffer_if.slave   s_axi,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Pointer difference that marks a full FIFO: only the wrap bit differs.
    localparam logic [PW-1:0] PTR_MSB = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem_q [DEPTH];
    logic [PW-1:0] rx_wr_q, rx_rd_q;
    logic          rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]    rx_head;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = ((rx_wr_q ^ rx_rd_q) == PTR_MSB);
    assign rx_head  = rx_mem_q[rx_rd_q[DEPTH_LOG2-1:0]];
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_push  = rx_valid && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem_q [DEPTH];
    logic [PW-1:0] tx_wr_q, tx_rd_q;
    logic          tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = ((tx_wr_q ^ tx_rd_q) == PTR_MSB);
    assign tx_valid = !tx_empty;
    // Masked so the output is 0 out of reset rather than stale memory.
    assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[DEPTH_LOG2-1:0]];
    assign tx_pop   = tx_valid && tx_ready;

    // ---------------- Read channel ----------------
    r_state_t    r_state_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rx_ovr_q;
    logic        ar_hs, stat_rd;
    logic [3:0]  ar_off;
    logic [31:0] status;

    assign ar_off  = s_axi.araddr[3:0];
    assign ar_hs   = (r_state_q == R_IDLE) && arready_q && s_axi.arvalid;
    assign stat_rd = ar_hs && (ar_off == 4'h8);
    assign status  = {29'b0, rx_ovr_q, tx_full, !rx_empty};
    // The head is popped at the edge that loads it into rdata.
    assign rx_pop  = (ar_hs && (ar_off == 4'h0) && !rx_empty) ||
                     ((r_state_q == R_WAIT) && !rx_empty);

    // The offset is fully decoded at the AR handshake; R_WAIT is only ever
    // entered for an RX data read, so nothing else needs remembering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (!arready_q) begin
                        arready_q <= 1'b1;
                    end else if (s_axi.arvalid) begin
                        arready_q <= 1'b0;
                        case (ar_off)
                            4'h0: begin
                                if (rx_empty) begin
                                    r_state_q <= R_WAIT;
                                end else begin
                                    rdata_q   <= {24'b0, rx_head};
                                    rresp_q   <= RESP_OKAY;
                                    rvalid_q  <= 1'b1;
                                    r_state_q <= R_RESP;
                                end
                            end
                            4'h8: begin
                                rdata_q   <= status;
                                rresp_q   <= RESP_OKAY;
                                rvalid_q  <= 1'b1;
                                r_state_q <= R_RESP;
                            end
                            default: begin
                                rdata_q   <= '0;
                                rresp_q   <= RESP_SLVERR;
                                rvalid_q  <= 1'b1;
                                r_state_q <= R_RESP;
                            end
                        endcase
                    end
                end
                R_WAIT: begin
                    if (!rx_empty) begin
                        rdata_q   <= {24'b0, rx_head};
                        rresp_q   <= RESP_OKAY;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // A fresh overrun beats the clear from a status read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovr_q <= 1'b0;
        end else if (rx_valid && rx_full && !rx_pop) begin
            rx_ovr_q <= 1'b1;
        end else if (stat_rd) begin
            rx_ovr_q <= 1'b0;
        end
    end

    // ---------------- Write channel ----------------
    w_state_t   w_state_q;
    logic       awready_q, wready_q, aw_have_q, w_have_q;
    logic [3:0] aw_off_q;
    logic [7:0] wbyte_q;
    logic       bvalid_q;
    logic [1:0] bresp_q;

    assign tx_push = ((w_state_q == W_IDLE) && aw_have_q && w_have_q &&
                      (aw_off_q == 4'h4) && !tx_full) ||
                     ((w_state_q == W_WAIT) && !tx_full);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[DEPTH_LOG2-1:0]] <= wbyte_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_off_q  <= '0;
            wbyte_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_have_q && w_have_q) begin
                        if (aw_off_q == 4'h4) begin
                            if (tx_full) begin
                                w_state_q <= W_WAIT;
                            end else begin
                                bresp_q   <= RESP_OKAY;
                                bvalid_q  <= 1'b1;
                                w_state_q <= W_RESP;
                            end
                        end else begin
                            bresp_q   <= RESP_SLVERR;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end else begin
                        // Each beat is captured on its own; its ready drops
                        // until the response completes.
                        if (!aw_have_q) begin
                            if (awready_q && s_axi.awvalid) begin
                                aw_have_q <= 1'b1;
                                awready_q <= 1'b0;
                                aw_off_q  <= s_axi.awaddr[3:0];
                            end else begin
                                awready_q <= 1'b1;
                            end
                        end
                        if (!w_have_q) begin
                            if (wready_q && s_axi.wvalid) begin
                                w_have_q <= 1'b1;
                                wready_q <= 1'b0;
                                wbyte_q  <= s_axi.wdata[7:0];
                            end else begin
                                wready_q <= 1'b1;
                            end
                        end
                    end
                end
                W_WAIT: begin
                    if (!tx_full) begin
                        bresp_q   <= RESP_OKAY;
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;

    // Address bits above the register window, the upper write-data bytes and
    // the strobes carry no meaning for a byte-wide UART.
    logic unused_bits;
    assign unused_bits = &{1'b0, s_axi.araddr[31:4], s_axi.awaddr[31:4],
                           s_axi.wdata[31:8], s_axi.wstrb};
endmodule

// File: tb/tb_uart_axi_buffer.sv
// tb/tb_uart_axi_buffer.sv - directed self-checking bench for uart_axi_buffer

module tb_uart_axi_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    uart_axi_buffer_if s_axi();

    uart_axi_buffer #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi    (s_axi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Outstanding-transaction bookkeeping: issued counts are stepped by the
    // stimulus, done counts by the compare process.
    int          rd_issued = 0, rd_done = 0;
    int          wr_issued = 0, wr_done = 0;
    logic [3:0]  rd_addr;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_byte;

    // Behavioural model: byte queues and the sticky overrun flag.
    logic [7:0]  mrx[$];
    logic [7:0]  mtx[$];
    logic        movr = 1'b0;
    logic [7:0]  tx_log[$];
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;
    logic [1:0]  last_bresp;

    always @(negedge clk) begin
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        if (rst) begin
            mrx.delete();
            mtx.delete();
            movr    = 1'b0;
            rd_done = rd_issued;
            wr_done = wr_issued;
        end else begin
            if (s_axi.bvalid) begin
                if (wr_done == wr_issued) begin
                    check("spurious_bvalid", 32'(s_axi.bvalid), 32'd0);
                end else if (s_axi.bready) begin
                    exp_r = (wr_addr == 4'h4) ? 2'b00 : 2'b10;
                    check("bresp", 32'(s_axi.bresp), 32'(exp_r));
                    if (wr_addr == 4'h4) mtx.push_back(wr_byte);
                    last_bresp = s_axi.bresp;
                    wr_done++;
                end
            end
            check("tx_valid", 32'(tx_valid), 32'(mtx.size() > 0));
            if (tx_valid && mtx.size() > 0) begin
                check("tx_data", 32'(tx_data), 32'(mtx[0]));
                if (tx_ready) begin
                    tx_log.push_back(tx_data);
                    void'(mtx.pop_front());
                end
            end
            if (s_axi.rvalid) begin
                if (rd_done == rd_issued) begin
                    check("spurious_rvalid", 32'(s_axi.rvalid), 32'd0);
                end else if (s_axi.rready) begin
                    exp_r = 2'b00;
                    exp_d = 32'd0;
                    if (rd_addr == 4'h0) begin
                        if (mrx.size() > 0) exp_d = {24'b0, mrx.pop_front()};
                    end else if (rd_addr == 4'h8) begin
                        exp_d = {29'b0, movr, mtx.size() == 16, mrx.size() > 0};
                        movr  = 1'b0;
                    end else begin
                        exp_r = 2'b10;
                    end
                    check("rdata", s_axi.rdata, exp_d);
                    check("rresp", 32'(s_axi.rresp), 32'(exp_r));
                    last_rdata = s_axi.rdata;
                    last_rresp = s_axi.rresp;
                    rd_done++;
                end
            end
            if (rx_valid) begin
                if (mrx.size() < 16) mrx.push_back(rx_data);
                else                 movr = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [3:0] a);
        int n = 0;
        while (!s_axi.arready && n < 100) begin tick(); n++; end
        if (n >= 100) check("arready_timeout", 32'd0, 32'd1);
        rd_addr       = a;
        s_axi.araddr  = {28'h7F00000, a};
        s_axi.arvalid = 1'b1;
        rd_issued++;
        tick();
        s_axi.arvalid = 1'b0;
    endtask

    task automatic wait_read();
        int n = 0;
        while (rd_done != rd_issued && n < 200) begin tick(); n++; end
        if (n >= 200) check("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] a);
        issue_read(a);
        wait_read();
    endtask

    task automatic issue_aw(input logic [3:0] a);
        int n = 0;
        while (!s_axi.awready && n < 100) begin tick(); n++; end
        if (n >= 100) check("awready_timeout", 32'd0, 32'd1);
        wr_addr       = a;
        s_axi.awaddr  = {28'h7F00000, a};
        s_axi.awvalid = 1'b1;
        wr_issued++;
        tick();
        s_axi.awvalid = 1'b0;
    endtask

    task automatic issue_w(input logic [7:0] d);
        int n = 0;
        while (!s_axi.wready && n < 100) begin tick(); n++; end
        if (n >= 100) check("wready_timeout", 32'd0, 32'd1);
        wr_byte      = d;
        s_axi.wdata  = {24'hABCDEF, d};
        s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
    endtask

    task automatic wait_write();
        int n = 0;
        while (wr_done != wr_issued && n < 200) begin tick(); n++; end
        if (n >= 200) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        issue_aw(a);
        issue_w(d);
        wait_write();
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (mtx.size() > 0 && n < 200) begin tick(); n++; end
        if (n >= 200) check("tx_drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        repeat (3) tick();
        check("rst_arready", 32'(s_axi.arready), 32'd0);
        check("rst_awready", 32'(s_axi.awready), 32'd0);
        check("rst_wready",  32'(s_axi.wready),  32'd0);
        check("rst_rvalid",  32'(s_axi.rvalid),  32'd0);
        check("rst_bvalid",  32'(s_axi.bvalid),  32'd0);
        check("rst_rdata",   s_axi.rdata,        32'd0);
        check("rst_tx",      {23'b0, tx_valid, tx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: three bytes in, three reads out in order
        rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
        do_read(4'h0); check("t1_byte0", last_rdata, 32'h41);
        do_read(4'h0); check("t1_byte1", last_rdata, 32'h42);
        do_read(4'h0); check("t1_byte2", last_rdata, 32'h43);
        check("t1_rresp", 32'(last_rresp), 32'd0);

        // 2: read of an empty RX FIFO is held until a byte arrives
        issue_read(4'h0);
        repeat (20) begin
            check("t2_held", 32'(s_axi.rvalid), 32'd0);
            tick();
        end
        rx_push(8'h55);
        check("t2_not_yet", 32'(s_axi.rvalid), 32'd0);
        tick();
        check("t2_rvalid", 32'(s_axi.rvalid), 32'd1);
        check("t2_rdata",  s_axi.rdata, 32'h55);
        wait_read();

        // 3: fill TX, the 17th write stalls until the transmitter drains
        for (int i = 0; i < 16; i++) do_write(4'h4, 8'(8'h10 + i));
        do_read(4'h8); check("t3_status_full", last_rdata, 32'h2);
        issue_aw(4'h4);
        issue_w(8'h20);
        repeat (10) begin
            check("t3_b_held", 32'(s_axi.bvalid), 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        wait_write();
        wait_tx_drain();
        check("t3_count", 32'(tx_log.size()), 32'd17);
        check("t3_first", 32'(tx_log[0]),  32'h10);
        check("t3_last",  32'(tx_log[16]), 32'h20);

        // 5: AW three cycles ahead of W, then an unmapped read
        issue_aw(4'h4);
        repeat (2) tick();
        check("t5_b_early", 32'(s_axi.bvalid), 32'd0);
        check("t5_wready",  32'(s_axi.wready), 32'd1);
        issue_w(8'h77);
        wait_write();
        wait_tx_drain();
        check("t5_tx", 32'(tx_log[17]), 32'h77);
        do_read(4'hC);
        check("t5_c_resp",  32'(last_rresp), 32'd2);
        check("t5_c_rdata", last_rdata, 32'd0);
        do_read(4'h4);
        check("rd_4_resp", 32'(last_rresp), 32'd2);
        do_write(4'h0, 8'h66);
        check("wr_0_resp", 32'(last_bresp), 32'd2);
        repeat (3) tick();
        check("wr_0_discard", 32'(tx_valid), 32'd0);

        // 4: overrun after 17 bytes, flag clears after one status read
        for (int i = 0; i < 17; i++) rx_push(8'(8'h60 + i));
        do_read(4'h8); check("t4_status_ovr", last_rdata, 32'h5);
        do_read(4'h8); check("t4_status_clr", last_rdata, 32'h1);
        do_read(4'h0); check("t4_head", last_rdata, 32'h60);

        // 6: reset while a read waits in R_WAIT
        rst = 1'b1; tick(); rst = 1'b0;
        do_read(4'h8); check("t6_cleared", last_rdata, 32'h0);
        issue_read(4'h0);
        repeat (5) tick();
        check("t6_waiting", 32'(s_axi.rvalid), 32'd0);
        rst = 1'b1; tick();
        check("t6_rst_arready", 32'(s_axi.arready), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("t6_arready", 32'(s_axi.arready), 32'd1);
        rx_push(8'h99);
        repeat (10) tick();
        do_read(4'h0); check("t6_fresh_read", last_rdata, 32'h99);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
